// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared constants, state type and helpers for the RAM
//               responder (main-memory model below the cache controllers).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Word width of every transfer on the cache-to-RAM interface
    localparam int DATA_W          = 32;
    // Address bus width seen by the responder (upper bits alias)
    localparam int ADDR_W          = 32;
    // Default number of cycles from request detection to response high
    localparam int DEFAULT_LATENCY = 4;
    // Default number of words of storage
    localparam int DEFAULT_DEPTH   = 1024;

    // Responder state: waiting for a new request, or counting out latency
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ram_state_t;

    // Width of the latency down-counter; a 1-cycle latency still needs one bit
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_word_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_word_array
// Description : DEPTH x DATA_W word storage with a synchronous write port and
//               a combinational read port. Contents start at zero and are
//               never cleared afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_word_array
    import ram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Storage is zero at time 0 only; reset deliberately does not touch it
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    // Commit one word per cycle when the controller asks for it
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read path is asynchronous so a completing read sees memory this cycle
    assign rdata_o = mem_q[raddr_i];

endmodule : ram_word_array
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Main-memory responder. Detects a new request as any change in
//               the {data, addr, wr} tuple while idle, latches it, waits a
//               fixed LATENCY, then completes the read or write from the
//               latched copy and raises response. Inputs that change while
//               busy are picked up by the next idle compare.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder
    import ram_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    output logic              response,
    output logic [DATA_W-1:0] out
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = cnt_width(LATENCY);
    // Counter load value: the detecting edge already accounts for one cycle
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ram_responder: DEPTH must be a power of two and at least 2");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("ram_responder: LATENCY must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State, shadows and registered outputs
    // ------------------------------------------------------------------------
    ram_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wr_q,    wr_d;
    logic              resp_q,  resp_d;
    logic [DATA_W-1:0] out_q,   out_d;

    // Storage interface
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // A request is "new" whenever the input tuple differs from the last one
    logic              req_new;

    // Only the low AW address bits index memory; the rest alias by design
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr_q[ADDR_W-1:AW];
    assign req_new        = ({data, addr, wr} != {data_q, addr_q, wr_q});

    // ------------------------------------------------------------------------
    // Word storage
    // ------------------------------------------------------------------------
    ram_word_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW-1:0]),
        .wdata_i (data_q),
        .raddr_i (addr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Next-state logic: accept a request when idle, count down, then complete
    // using only the latched shadows so mid-transaction input changes are inert
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        resp_d  = resp_q;
        out_d   = out_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_new) begin
                    data_d  = data;
                    addr_d  = addr;
                    wr_d    = wr;
                    resp_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (wr_q) begin
                        // Write echoes the stored word back on out
                        mem_we = 1'b1;
                        out_d  = data_q;
                    end else begin
                        out_d  = mem_rdata;
                    end
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; async reset abandons any in-flight transaction, and
    // since mem_we only fires from BUSY no write can follow a reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
        end
    end

    assign response = resp_q;
    assign out      = out_q;

endmodule : ram_responder
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Self-checking bench for ram_responder. A transaction-level
//               model (completion edge = detect edge + LATENCY, memory as a
//               plain array indexed by addr modulo DEPTH) is compared against
//               the DUT every cycle; directed scenarios add literal checks.
//               A second instance exercises the LATENCY=1 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;
    localparam int DEPTH1 = 16;
    localparam int LAT1   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] data = '0;
    logic [31:0] addr = '0;
    logic        wr   = 1'b0;
    logic        response;
    logic [31:0] out;

    logic [31:0] d1 = '0;
    logic [31:0] a1 = '0;
    logic        w1 = 1'b0;
    logic        resp1;
    logic [31:0] out1;

    int checks = 0;
    int passes = 0;

    ram_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .addr     (addr),
        .wr       (wr),
        .response (response),
        .out      (out)
    );

    ram_responder #(.DEPTH(DEPTH1), .LATENCY(LAT1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .data     (d1),
        .addr     (a1),
        .wr       (w1),
        .response (resp1),
        .out      (out1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Transaction-level reference model for dut
    // ------------------------------------------------------------------------
    longint      edge_cnt  = 0;
    longint      m_done    = 0;
    bit          m_pending = 1'b0;
    logic [31:0] m_d       = '0;
    logic [31:0] m_a       = '0;
    logic        m_w       = 1'b0;
    logic        m_resp    = 1'b1;
    logic [31:0] m_out     = '0;
    bit   [31:0] m_mem [DEPTH];

    // Model step: a request is accepted when idle and the tuple changed;
    // it completes exactly LAT edges after the accepting edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 1'b0;
            m_d       <= '0;
            m_a       <= '0;
            m_w       <= 1'b0;
            m_resp    <= 1'b1;
            m_out     <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (m_pending) begin
                if (edge_cnt == m_done) begin
                    if (m_w) begin
                        m_mem[m_a % DEPTH] <= m_d;
                        m_out              <= m_d;
                    end else begin
                        m_out              <= m_mem[m_a % DEPTH];
                    end
                    m_pending <= 1'b0;
                    m_resp    <= 1'b1;
                end
            end else if ({data, addr, wr} != {m_d, m_a, m_w}) begin
                m_d       <= data;
                m_a       <= addr;
                m_w       <= wr;
                m_pending <= 1'b1;
                m_done    <= edge_cnt + LAT;
                m_resp    <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        $display("FAIL %s: timeout waiting for response, got none expected done", name);
    endtask

    // Every-cycle comparison of dut against the model, away from the edge
    always @(negedge clk) begin
        chk("model_response", {31'b0, response}, {31'b0, m_resp});
        chk("model_out", out, m_out);
    end

    function automatic logic resp_of(input bit sel);
        return sel ? resp1 : response;
    endfunction

    task automatic drive(input bit sel, input logic [31:0] d, input logic [31:0] a, input logic w);
        if (sel) begin
            d1 = d; a1 = a; w1 = w;
        end else begin
            data = d; addr = a; wr = w;
        end
    endtask

    // Count busy cycles until response returns high (bounded)
    task automatic wait_done(input bit sel, input string name, output int lows);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_of(sel) == 1'b0) lows++;
            else if (lows > 0) return;
        end
        fail_timeout(name);
    endtask

    task automatic run_txn(input bit sel, input string name, input logic [31:0] d,
                           input logic [31:0] a, input logic w, input int exp_lows,
                           input logic [31:0] exp_out);
        int lows;
        drive(sel, d, a, w);
        wait_done(sel, name, lows);
        chk({name, "_lowcycles"}, lows, exp_lows);
        chk({name, "_out"}, sel ? out1 : out, exp_out);
    endtask

    initial begin
        int          lows;
        logic [31:0] ra;
        logic [31:0] rhi;

        // 1. Reset and idle
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_response", {31'b0, response}, 32'd1);
        chk("reset_out", out, 32'd0);
        chk("reset_out_lat1", out1, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (response == 1'b0) lows++;
        end
        chk("idle_after_reset_lows", lows, 0);

        // 2. Write
        run_txn(0, "write5", 32'hDEADBEEF, 32'd5, 1'b1, 4, 32'hDEADBEEF);

        // 3. Read and alias
        run_txn(0, "read5",    32'hDEADBEEF, 32'd5,    1'b0, 4, 32'hDEADBEEF);
        run_txn(0, "read1029", 32'hDEADBEEF, 32'd1029, 1'b0, 4, 32'hDEADBEEF);
        run_txn(0, "read6",    32'h0,        32'd6,    1'b0, 4, 32'h0);

        // 4. Change during BUSY
        drive(0, 32'h0, 32'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 32'hA5A5A5A5, 32'd9, 1'b1);
        wait_done(0, "chg_first", lows);
        chk("chg_first_out", out, 32'hDEADBEEF);
        @(negedge clk);
        chk("chg_second_detected", {31'b0, response}, 32'd0);
        wait_done(0, "chg_second", lows);
        chk("chg_second_out", out, 32'hA5A5A5A5);
        run_txn(0, "read9", 32'h0, 32'd9, 1'b0, 4, 32'hA5A5A5A5);

        // 5. Reset mid-BUSY
        drive(0, 32'h12345678, 32'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_response", {31'b0, response}, 32'd1);
        chk("rst_async_out", out, 32'd0);
        @(negedge clk);
        drive(0, 32'h0, 32'd7, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(0, "read7_after_rst", lows);
        chk("read7_after_rst_lowcycles", lows, 4);
        chk("read7_after_rst_out", out, 32'h0);

        // 6. LATENCY=1 build
        run_txn(1, "lat1_write3", 32'h1, 32'd3, 1'b1, 1, 32'h1);
        run_txn(1, "lat1_read3",  32'h1, 32'd3, 1'b0, 1, 32'h1);

        // Randomised traffic, including mid-flight changes and resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                ra  = 32'($urandom_range(0, 31));
                rhi = $urandom;
                if ($urandom_range(0, 3) == 0) ra = ra | (rhi << 10);
                drive(0, $urandom, ra, 1'($urandom_range(0, 1)));
            end
        end

        // Let any in-flight transaction settle under the compare process
        for (int i = 0; i < 2 * LAT + 4; i++) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_ram_responder
`default_nettype wire
